pipe_hazard_ctl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Detects load-use hazards and taken leaps resolved in MEM, and runs the data-memory request/acknowledge handshake.
- Drives the hold and flush controls of every pipeline register.
- Owns a stall-cycle performance counter and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, MEM-stage leaps and
// data-memory handshake, with a stall-cycle counter and a sticky timeout error.
module pipe_hazard_ctl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_dest_reg,
    input  logic              ex_mem_to_reg,
    input  logic              mem_access,
    input  logic              mem_leap,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic              ex_mem_hold,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    // state   | meaning
    // RUN     | normal flow; a memory access is requested directly from MEM
    // MEMWAIT | access outstanding, pipeline frozen until dmem_ack
    // ERR     | memory timed out; frozen until reset
    typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_ERR} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                frozen, leap, hazard, src1_hit, src2_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        frozen       = 1'b0;
        dmem_req     = 1'b0;
        mem_err      = 1'b0;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ack) begin
                    frozen     = 1'b1;
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_MEMWAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    frozen = 1'b1;
                    if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) state_d = ST_ERR;
                    else wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                frozen  = 1'b1;
                mem_err = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        // A leap held in EX/MEM during a freeze is acted on in the release cycle.
        src1_hit = id_use_rs1 && (id_rs1 == ex_dest_reg);
        src2_hit = id_use_rs2 && (id_rs2 == ex_dest_reg);
        leap     = !frozen && mem_leap;
        hazard   = !frozen && !leap && ex_mem_to_reg && (ex_dest_reg != 5'd0)
                   && (src1_hit || src2_hit);

        if (frozen) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (leap) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hazard) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_flush  = 1'b1;
        end

        if (!reset) begin
            dmem_req     = 1'b0;
            mem_err      = 1'b0;
            pc_hold      = 1'b0;
            if_id_hold   = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_hold   = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_hold  = 1'b0;
            ex_mem_flush = 1'b0;
            mem_wb_flush = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (pc_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: a cycle-level reference model queues
// expected outputs, and a negedge monitor compares them against the DUT.
module tb_pipe_hazard_ctl;
    localparam int TMO = 15;
    localparam int PW  = 8;

    logic clk, reset;
    logic [4:0] id_rs1, id_rs2, ex_dest_reg;
    logic id_use_rs1, id_use_rs2, ex_mem_to_reg, mem_access, mem_leap, dmem_ack;
    logic dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic ex_mem_hold, ex_mem_flush, mem_wb_flush, mem_err;
    logic [PW-1:0] stall_cnt;

    pipe_hazard_ctl #(.MEM_TIMEOUT(TMO), .CNT_W(4), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_dest_reg(ex_dest_reg), .ex_mem_to_reg(ex_mem_to_reg),
        .mem_access(mem_access), .mem_leap(mem_leap), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
        .ex_mem_hold(ex_mem_hold), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    // ctl bit order: req pc ifh iff idh idf exh exf wbf err
    typedef struct packed {
        logic [9:0]    ctl;
        logic [PW-1:0] stall;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // reference model state: consecutive unacknowledged cycles of a pending access
    int  m_unacked = 0;
    bit  m_err     = 0;
    int  m_stall   = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input bit rst, input bit acc, input bit ack, input bit lp,
                          input bit ld, input int dst, input bit u1, input int r1,
                          input bit u2, input int r2);
        reset = rst; mem_access = acc; dmem_ack = ack; mem_leap = lp;
        ex_mem_to_reg = ld; ex_dest_reg = 5'(dst);
        id_use_rs1 = u1; id_rs1 = 5'(r1); id_use_rs2 = u2; id_rs2 = 5'(r2);
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, advance.
    task automatic step();
        exp_t e;
        bit pending, frozen, lp, haz;
        e = '0;
        if (!reset) begin
            m_unacked = 0; m_err = 0; m_stall = 0;
        end else begin
            e.stall = PW'(m_stall);
            pending = (m_unacked > 0) || mem_access;
            frozen  = m_err || (pending && !dmem_ack);
            lp      = !frozen && mem_leap;
            haz     = !frozen && !lp && ex_mem_to_reg && ex_dest_reg != 0 &&
                      ((id_use_rs1 && id_rs1 == ex_dest_reg) || (id_use_rs2 && id_rs2 == ex_dest_reg));
            if (frozen)   e.ctl = 10'b1_1_1_0_1_0_1_0_1_0;
            else if (lp)  e.ctl = 10'b0_0_0_1_0_1_0_1_0_0;
            else if (haz) e.ctl = 10'b0_1_1_0_0_1_0_0_0_0;
            e.ctl[9] = !m_err && pending;
            e.ctl[0] = m_err;
            if (e.ctl[8] && m_stall < (1 << PW) - 1) m_stall++;
            if (!m_err) begin
                if (pending && !dmem_ack) begin
                    m_unacked++;
                    if (m_unacked > TMO) m_err = 1;
                end else m_unacked = 0;
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    task automatic do_reset();
        set_in(0, 1, 0, 1, 1, 3, 1, 3, 1, 3);
        step();
        step();
        idle(1);
    endtask

    initial begin : monitor
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {dmem_req, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                       ex_mem_hold, ex_mem_flush, mem_wb_flush, mem_err};
                n_tests++;
                if (act !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cyc=%0d actual=%b expected=%b", cyc, act, e.ctl);
                end
                n_tests++;
                if (stall_cnt !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall_cnt cyc=%0d actual=%0d expected=%0d", cyc, stall_cnt, e.stall);
                end
            end
        end
    end

    initial begin : driver
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();
        // load-use on rs2, then r0 is never a hazard
        set_in(1, 0, 0, 0, 1, 5, 0, 0, 1, 5); step();
        idle(1);
        set_in(1, 0, 0, 0, 1, 0, 1, 0, 0, 0); step();
        // memory access acked after three cycles, then immediate ack
        for (int i = 0; i < 4; i++) begin
            set_in(1, (i == 0), (i == 3), 0, 0, 0, 0, 0, 0, 0); step();
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        // leap with a simultaneous load-use
        set_in(1, 0, 0, 1, 1, 7, 1, 7, 0, 0); step();
        // leap held through a memory wait
        for (int i = 0; i < 3; i++) begin
            set_in(1, (i == 0), (i == 2), 1, 0, 0, 0, 0, 0, 0); step();
        end
        idle(1);
        // timeout into ERR, long enough to saturate stall_cnt, then reset mid-ERR
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 280; i++) begin
            set_in(1, 0, 0, i[0], 1, 2, 1, 2, 0, 0); step();
        end
        do_reset();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_err && $urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
                set_in(1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                       $urandom_range(0, 9) < 2, $urandom_range(0, 1),
                       $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                       $urandom_range(0, 1), $urandom_range(0, 3));
                step();
                if ($urandom_range(0, 299) == 0) begin
                    for (int k = 0; k < 20; k++) begin
                        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
                    end
                end
            end
        end
        @(negedge clk); #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
